// File: rtl/compare_stats.sv
// Windowed comparator-result statistics: classifies gt/lt/eq flags over WINDOW
// accepted samples and presents GT/LT/EQ/error counts plus the longest EQ run.
module compare_stats #(
    parameter int WINDOW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       gt,
    input  logic       lt,
    input  logic       eq,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] gt_cnt,
    output logic [7:0] lt_cnt,
    output logic [7:0] eq_cnt,
    output logic [7:0] err_cnt,
    output logic [7:0] max_eq_run
);

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

    state_t     state;
    state_t     stateNext;

    logic       accept;
    logic       lastAccept;
    logic       handshake;
    logic       isGt;
    logic       isLt;
    logic       isEq;
    logic       isErr;

    logic [7:0] gtAcc;
    logic [7:0] ltAcc;
    logic [7:0] eqAcc;
    logic [7:0] errAcc;
    logic [7:0] runCnt;
    logic [7:0] maxRun;
    logic [7:0] sampleIdx;

    logic [7:0] gtNext;
    logic [7:0] ltNext;
    logic [7:0] eqNext;
    logic [7:0] errNext;
    logic [7:0] runNext;
    logic [7:0] maxNext;

    assign in_ready   = (state == COLLECT);
    assign out_valid  = (state == REPORT);

    assign accept     = in_valid && in_ready;
    assign lastAccept = accept && (sampleIdx == LAST_IDX);
    assign handshake  = (state == REPORT) && out_ready;

    assign isGt  = ({gt, lt, eq} == 3'b100);
    assign isLt  = ({gt, lt, eq} == 3'b010);
    assign isEq  = ({gt, lt, eq} == 3'b001);
    assign isErr = !(isGt || isLt || isEq);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        if (clear) begin
            stateNext = COLLECT;
        end else if (lastAccept) begin
            stateNext = REPORT;
        end else if (handshake) begin
            stateNext = COLLECT;
        end
    end

    // Post-update values; the final sample of a window is folded in before capture.
    always_comb begin
        gtNext  = gtAcc + (isGt ? 8'd1 : 8'd0);
        ltNext  = ltAcc + (isLt ? 8'd1 : 8'd0);
        eqNext  = eqAcc + (isEq ? 8'd1 : 8'd0);
        errNext = errAcc + (isErr ? 8'd1 : 8'd0);
        runNext = isEq ? runCnt + 8'd1 : 8'd0;
        maxNext = (runNext > maxRun) ? runNext : maxRun;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gtAcc      <= '0;
            ltAcc      <= '0;
            eqAcc      <= '0;
            errAcc     <= '0;
            runCnt     <= '0;
            maxRun     <= '0;
            sampleIdx  <= '0;
            gt_cnt     <= '0;
            lt_cnt     <= '0;
            eq_cnt     <= '0;
            err_cnt    <= '0;
            max_eq_run <= '0;
        end else if (clear) begin
            gtAcc      <= '0;
            ltAcc      <= '0;
            eqAcc      <= '0;
            errAcc     <= '0;
            runCnt     <= '0;
            maxRun     <= '0;
            sampleIdx  <= '0;
            gt_cnt     <= '0;
            lt_cnt     <= '0;
            eq_cnt     <= '0;
            err_cnt    <= '0;
            max_eq_run <= '0;
        end else if (handshake) begin
            // Summary keeps its last value; out_valid already marks it stale.
            gtAcc      <= '0;
            ltAcc      <= '0;
            eqAcc      <= '0;
            errAcc     <= '0;
            runCnt     <= '0;
            maxRun     <= '0;
            sampleIdx  <= '0;
        end else if (accept) begin
            gtAcc     <= gtNext;
            ltAcc     <= ltNext;
            eqAcc     <= eqNext;
            errAcc    <= errNext;
            runCnt    <= runNext;
            maxRun    <= maxNext;
            sampleIdx <= sampleIdx + 8'd1;
            if (lastAccept) begin
                gt_cnt     <= gtNext;
                lt_cnt     <= ltNext;
                eq_cnt     <= eqNext;
                err_cnt    <= errNext;
                max_eq_run <= maxNext;
            end
        end
    end

endmodule

// File: tb/tb_compare_stats.sv
// Self-checking bench for compare_stats: directed scenarios plus randomized windows
// scored against a per-window statistics model.
module tb_compare_stats;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       inValid;
    logic       inReady;
    logic       gt, lt, eq;
    logic       outValid;
    logic       outReady;
    logic [7:0] gtCnt, ltCnt, eqCnt, errCnt, maxEqRun;

    logic       clear4;
    logic       inValid4;
    logic       inReady4;
    logic       gt4, lt4, eq4;
    logic       outValid4;
    logic       outReady4;
    logic [7:0] gtCnt4, ltCnt4, eqCnt4, errCnt4, maxEqRun4;

    int checks = 0;
    int errors = 0;

    wire [39:0] stats8 = {gtCnt, ltCnt, eqCnt, errCnt, maxEqRun};
    wire [39:0] stats4 = {gtCnt4, ltCnt4, eqCnt4, errCnt4, maxEqRun4};

    compare_stats #(.WINDOW(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(inValid), .in_ready(inReady),
        .gt(gt), .lt(lt), .eq(eq),
        .out_valid(outValid), .out_ready(outReady),
        .gt_cnt(gtCnt), .lt_cnt(ltCnt), .eq_cnt(eqCnt),
        .err_cnt(errCnt), .max_eq_run(maxEqRun)
    );

    compare_stats #(.WINDOW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear4),
        .in_valid(inValid4), .in_ready(inReady4),
        .gt(gt4), .lt(lt4), .eq(eq4),
        .out_valid(outValid4), .out_ready(outReady4),
        .gt_cnt(gtCnt4), .lt_cnt(ltCnt4), .eq_cnt(eqCnt4),
        .err_cnt(errCnt4), .max_eq_run(maxEqRun4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: statistics of one complete window, packed as {gt,lt,eq,err,maxRun}.
    function automatic logic [39:0] refStats(input logic [2:0] res[$]);
        int g = 0, l = 0, e = 0, x = 0, run = 0, best = 0;
        foreach (res[i]) begin
            if (res[i] == 3'b001) begin
                e++;
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
                if (res[i] == 3'b100) g++;
                else if (res[i] == 3'b010) l++;
                else x++;
            end
        end
        return {8'(g), 8'(l), 8'(e), 8'(x), 8'(best)};
    endfunction

    function automatic logic [2:0] randLegal();
        logic [2:0] one;
        one = 3'b100;
        return one >> $urandom_range(0, 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f);
        inValid = v;
        {gt, lt, eq} = f;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || stats8 !== 40'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b stats=%h, want 1 0 0", inReady, outValid, stats8);
        end
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [2:0] q[$];
        q = {3'b100, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b100};
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, q[i]);
            tick();
            if (i == 6) begin
                checks++;
                if (outValid !== 1'b0) begin
                    errors++;
                    $display("FAIL directed_early: out_valid=%b after 7 accepts, want 0", outValid);
                end
            end
        end
        drive(1'b0, 3'b000);
        checks++;
        if (outValid !== 1'b1 || stats8 !== 40'h02_01_05_00_03) begin
            errors++;
            $display("FAIL directed_stats: out_valid=%b stats=%h, want 1 0201050003", outValid, stats8);
        end
        tick();
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL directed_return: out_valid=%b in_ready=%b, want 0 1", outValid, inReady);
        end
    endtask

    task automatic test_illegal_w4();
        logic [2:0] q[$];
        q = {3'b000, 3'b111, 3'b001, 3'b110};
        outReady4 = 1'b1;
        foreach (q[i]) begin
            inValid4 = 1'b1;
            {gt4, lt4, eq4} = q[i];
            tick();
        end
        inValid4 = 1'b0;
        checks++;
        if (outValid4 !== 1'b1 || stats4 !== 40'h00_00_01_03_01) begin
            errors++;
            $display("FAIL illegal_w4: out_valid=%b stats=%h, want 1 0000010301", outValid4, stats4);
        end
        tick();
        checks++;
        if (outValid4 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_w4_return: out_valid=%b, want 0", outValid4);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]  q[$];
        logic [39:0] exp;
        outReady = 1'b0;
        for (int i = 0; i < 8; i++) q.push_back(randLegal());
        foreach (q[i]) begin
            drive(1'b1, q[i]);
            tick();
        end
        exp = refStats(q);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 3'($urandom));
            tick();
            checks++;
            if (outValid !== 1'b1 || inReady !== 1'b0 || stats8 !== exp) begin
                errors++;
                $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b stats=%h, want 1 0 %h",
                         c, outValid, inReady, stats8, exp);
            end
        end
        drive(1'b0, 3'b000);
        outReady = 1'b1;
        tick();
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b, want 0", outValid);
        end
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(randLegal());
        foreach (q[i]) begin
            drive(1'b1, q[i]);
            tick();
            if (i < 7) begin
                checks++;
                if (outValid !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_next_early%0d: out_valid=%b, want 0", i, outValid);
                end
            end
        end
        drive(1'b0, 3'b000);
        checks++;
        if (outValid !== 1'b1 || stats8 !== refStats(q)) begin
            errors++;
            $display("FAIL hold_next_stats: out_valid=%b stats=%h, want 1 %h", outValid, stats8, refStats(q));
        end
        tick();
    endtask

    task automatic test_clear();
        logic [2:0] q[$];
        outReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b100);
            tick();
        end
        drive(1'b0, 3'b000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (outValid !== 1'b0 || stats8 !== 40'h0) begin
            errors++;
            $display("FAIL clear_mid: out_valid=%b stats=%h, want 0 0", outValid, stats8);
        end
        outReady = 1'b0;
        for (int i = 0; i < 8; i++) q.push_back(randLegal());
        foreach (q[i]) begin
            drive(1'b1, q[i]);
            tick();
            if (i < 7) begin
                checks++;
                if (outValid !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_restart%0d: out_valid=%b, want 0", i, outValid);
                end
            end
        end
        drive(1'b0, 3'b000);
        checks++;
        if (outValid !== 1'b1 || stats8 !== refStats(q)) begin
            errors++;
            $display("FAIL clear_fresh_stats: out_valid=%b stats=%h, want 1 %h", outValid, stats8, refStats(q));
        end
        clear = 1'b1;
        outReady = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1 || stats8 !== 40'h0) begin
            errors++;
            $display("FAIL clear_vs_ready: out_valid=%b in_ready=%b stats=%h, want 0 1 0", outValid, inReady, stats8);
        end
    endtask

    task automatic test_async_reset();
        outReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'b100);
            tick();
        end
        drive(1'b0, 3'b000);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1 || stats8 !== 40'h0) begin
            errors++;
            $display("FAIL async_report: out_valid=%b in_ready=%b stats=%h, want 0 1 0", outValid, inReady, stats8);
        end
        #1 rst_n = 1'b1;
        tick();
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b010);
            tick();
        end
        drive(1'b0, 3'b000);
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'b001);
            tick();
            if (i < 7) begin
                checks++;
                if (outValid !== 1'b0) begin
                    errors++;
                    $display("FAIL async_restart%0d: out_valid=%b, want 0", i, outValid);
                end
            end
        end
        drive(1'b0, 3'b000);
        checks++;
        if (outValid !== 1'b1 || stats8 !== 40'h00_00_08_00_08) begin
            errors++;
            $display("FAIL async_eq_window: out_valid=%b stats=%h, want 1 0000080008", outValid, stats8);
        end
        tick();
    endtask

    task automatic test_random_windows();
        logic [2:0]  q[$];
        logic [39:0] exp;
        int          total;
        outReady = 1'b1;
        for (int w = 0; w < 100; w++) begin
            q.delete();
            for (int i = 0; i < 8; i++) q.push_back(randLegal());
            foreach (q[i]) begin
                drive(1'b1, q[i]);
                tick();
                if (i < 7) begin
                    checks++;
                    if (outValid !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_w%0d_early%0d: out_valid=%b, want 0", w, i, outValid);
                    end
                    drive(1'b0, 3'($urandom));
                    tick();
                end
            end
            exp   = refStats(q);
            total = int'(gtCnt) + int'(ltCnt) + int'(eqCnt) + int'(errCnt);
            checks++;
            if (outValid !== 1'b1 || stats8 !== exp || total != 8) begin
                errors++;
                $display("FAIL rand_w%0d_stats: out_valid=%b stats=%h sum=%0d, want 1 %h 8",
                         w, outValid, stats8, total, exp);
            end
            drive(1'b0, 3'($urandom));
            tick();
            checks++;
            if (outValid !== 1'b0) begin
                errors++;
                $display("FAIL rand_w%0d_return: out_valid=%b, want 0", w, outValid);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        outReady  = 1'b0;
        clear4    = 1'b0;
        inValid4  = 1'b0;
        outReady4 = 1'b0;
        {gt4, lt4, eq4} = 3'b000;
        drive(1'b0, 3'b000);

        test_reset();
        test_directed();
        test_illegal_w4();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random_windows();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
